// File: rtl/pll_lock_supervisor_if.sv
// Bus between the PLL lock supervisor and its surroundings.
// Inputs to the supervisor: INIT_DONE (sync level), PLL_LOCK and MON_TOGGLE (async).
// Outputs: PLL_POWERDOWN_N, CLK_OK, FAULT, RESTART_CNT[3:0], FREQ_COUNT[15:0], FREQ_VALID.
interface pll_lock_supervisor_if;
  logic        INIT_DONE;
  logic        PLL_LOCK;
  logic        MON_TOGGLE;
  logic        PLL_POWERDOWN_N;
  logic        CLK_OK;
  logic        FAULT;
  logic [3:0]  RESTART_CNT;
  logic [15:0] FREQ_COUNT;
  logic        FREQ_VALID;

  // Supervisor side
  modport slave (
    input  INIT_DONE, PLL_LOCK, MON_TOGGLE,
    output PLL_POWERDOWN_N, CLK_OK, FAULT, RESTART_CNT, FREQ_COUNT, FREQ_VALID
  );

  // System / stimulus side
  modport master (
    output INIT_DONE, PLL_LOCK, MON_TOGGLE,
    input  PLL_POWERDOWN_N, CLK_OK, FAULT, RESTART_CNT, FREQ_COUNT, FREQ_VALID
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL powerdown, debounces lock, measures the
// monitored clock frequency per window and retries / faults on failure.
// Ports: CLK, RST (sync, active-high), bus (pll_lock_supervisor_if.slave) carrying
// INIT_DONE, PLL_LOCK, MON_TOGGLE in and PLL_POWERDOWN_N, CLK_OK, FAULT,
// RESTART_CNT, FREQ_COUNT, FREQ_VALID out (all outputs registered).
module pll_lock_supervisor #(
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned MIN_EDGES     = 496,
  parameter int unsigned MAX_EDGES     = 528,
  parameter int unsigned LOCK_DEBOUNCE = 16,
  parameter int unsigned PD_HOLD       = 64,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  pll_lock_supervisor_if.slave bus
);

  localparam int unsigned WIN_W = (WINDOW > 1)       ? $clog2(WINDOW)       : 1;
  localparam int unsigned PD_W  = (PD_HOLD > 1)      ? $clog2(PD_HOLD)      : 1;
  localparam int unsigned TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned DEB_W = $clog2(LOCK_DEBOUNCE + 1);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POWERDOWN = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_MEASURE   = 3'd3,
    S_RUNNING   = 3'd4,
    S_FAULT_ST  = 3'd5
  } state_e;

  state_e             state_q;
  logic               lock_meta_q, lock_sync_q;
  logic               tog_meta_q, tog_sync_q, tog_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [PD_W-1:0]    pd_cnt_q;
  logic [TO_W-1:0]    wt_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               pd_n_q, clk_ok_q, fault_q, freq_valid_q;
  logic [3:0]         restart_q;
  logic [CNT_W-1:0]   freq_count_q;

  logic               stable_c, edge_c, win_close_c, in_range_c, retry_c, retry_ok_c;

  // Debounce, edge detect and window bookkeeping
  always_comb begin
    deb_cnt_d = '0;
    if (lock_sync_q) begin
      deb_cnt_d = (deb_cnt_q == DEB_W'(LOCK_DEBOUNCE)) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
    end
    // Stable lock is judged on the updated count so a low sample drops it in the same cycle
    stable_c    = (deb_cnt_d == DEB_W'(LOCK_DEBOUNCE));
    edge_c      = tog_sync_q ^ tog_prev_q;
    edge_cnt_d  = (edge_cnt_q == 16'hFFFF) ? edge_cnt_q : edge_cnt_q + CNT_W'(edge_c);
    win_close_c = (win_cnt_q == WIN_W'(WINDOW - 1));
    in_range_c  = (edge_cnt_d >= CNT_W'(MIN_EDGES)) && (edge_cnt_d <= CNT_W'(MAX_EDGES));
    retry_ok_c  = (restart_q < 4'(MAX_RETRIES));
  end

  // One retry request per cycle, whichever failure caused it
  always_comb begin
    retry_c = 1'b0;
    if (bus.INIT_DONE) begin
      case (state_q)
        S_WAIT_LOCK: retry_c = !stable_c && (wt_cnt_q == TO_W'(LOCK_TIMEOUT - 1));
        S_MEASURE:   retry_c = win_close_c && !in_range_c;
        S_RUNNING:   retry_c = !stable_c || (win_close_c && !in_range_c);
        default:     retry_c = 1'b0;
      endcase
    end
  end

  // Synchronizers, counters and state machine
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      tog_meta_q   <= 1'b0;
      tog_sync_q   <= 1'b0;
      tog_prev_q   <= 1'b0;
      deb_cnt_q    <= '0;
      pd_cnt_q     <= '0;
      wt_cnt_q     <= '0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      pd_n_q       <= 1'b0;
      clk_ok_q     <= 1'b0;
      fault_q      <= 1'b0;
      freq_valid_q <= 1'b0;
      restart_q    <= '0;
      freq_count_q <= '0;
    end else begin
      lock_meta_q  <= bus.PLL_LOCK;
      lock_sync_q  <= lock_meta_q;
      tog_meta_q   <= bus.MON_TOGGLE;
      tog_sync_q   <= tog_meta_q;
      tog_prev_q   <= tog_sync_q;
      deb_cnt_q    <= deb_cnt_d;
      freq_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          pd_n_q   <= 1'b0;
          clk_ok_q <= 1'b0;
          if (bus.INIT_DONE) begin
            pd_cnt_q <= '0;
            state_q  <= S_POWERDOWN;
          end
        end
        S_POWERDOWN: begin
          if (pd_cnt_q == PD_W'(PD_HOLD - 1)) begin
            pd_n_q   <= 1'b1;
            wt_cnt_q <= '0;
            state_q  <= S_WAIT_LOCK;
          end else begin
            pd_cnt_q <= pd_cnt_q + PD_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (stable_c) begin
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            state_q    <= S_MEASURE;
          end else begin
            wt_cnt_q <= wt_cnt_q + TO_W'(1);
          end
        end
        S_MEASURE, S_RUNNING: begin
          // An edge seen in the closing cycle belongs to the window being closed
          if (win_close_c) begin
            freq_count_q <= edge_cnt_d;
            freq_valid_q <= 1'b1;
            edge_cnt_q   <= '0;
            win_cnt_q    <= '0;
            if (in_range_c) begin
              clk_ok_q <= 1'b1;
              state_q  <= S_RUNNING;
            end
          end else begin
            edge_cnt_q <= edge_cnt_d;
            win_cnt_q  <= win_cnt_q + WIN_W'(1);
          end
        end
        S_FAULT_ST: begin
          pd_n_q   <= 1'b0;
          clk_ok_q <= 1'b0;
          fault_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase

      // Retry overrides the normal progression above
      if (retry_c) begin
        pd_n_q   <= 1'b0;
        clk_ok_q <= 1'b0;
        pd_cnt_q <= '0;
        if (retry_ok_c) begin
          restart_q <= restart_q + 4'd1;
          state_q   <= S_POWERDOWN;
        end else begin
          fault_q <= 1'b1;
          state_q <= S_FAULT_ST;
        end
      end

      // Losing INIT_DONE sends everything but FAULT_ST back to IDLE
      if (!bus.INIT_DONE && (state_q != S_FAULT_ST)) begin
        pd_n_q   <= 1'b0;
        clk_ok_q <= 1'b0;
        state_q  <= S_IDLE;
      end
    end
  end

  assign bus.PLL_POWERDOWN_N = pd_n_q;
  assign bus.CLK_OK          = clk_ok_q;
  assign bus.FAULT           = fault_q;
  assign bus.RESTART_CNT     = restart_q;
  assign bus.FREQ_COUNT      = freq_count_q;
  assign bus.FREQ_VALID      = freq_valid_q;

endmodule
